// File: rtl/complex_mult_pkg.sv
// ============================================================================
//  Module   : complex_mult_pkg
//  Purpose  : Shared types, LFSR taps and expected-product helper for the
//             complex multiplier requester.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package complex_mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          DATA_WIDTH_DEF = 8;
    // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Operands arrive sign-extended; the caller keeps the low 2*DATA_WIDTH bits.
    function automatic logic [63:0] cmul_expected(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input logic signed [31:0] c,
        input logic signed [31:0] d
    );
        logic signed [31:0] re;
        logic signed [31:0] im;
        re = a * c - b * d;
        im = a * d + b * c;
        return {im, re};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO holding operand sets of outstanding requests.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/complex_mult_requester.sv
// ============================================================================
//  Module   : complex_mult_requester
//  Purpose  : LFSR-driven traffic source and result checker for a complex
//             multiplier with valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module complex_mult_requester
    import complex_mult_pkg::*;
#(
    parameter int          DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int          FIFO_DEPTH = 4,
    parameter int          NUM_TRANS  = 16,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_5EED,
    parameter logic [7:0]  READY_PAT  = 8'hFF,
    parameter int          TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    op_ready,
    output logic                    op_val,
    output logic [DATA_WIDTH-1:0]   op_1_re,
    output logic [DATA_WIDTH-1:0]   op_1_im,
    output logic [DATA_WIDTH-1:0]   op_2_re,
    output logic [DATA_WIDTH-1:0]   op_2_im,
    input  logic                    res_val,
    input  logic [2*DATA_WIDTH-1:0] result_re,
    input  logic [2*DATA_WIDTH-1:0] result_im,
    output logic                    res_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [15:0]             err_cnt
);

    localparam int          DW          = DATA_WIDTH;
    localparam int          OPW         = 4 * DATA_WIDTH;
    localparam int          RW          = 2 * DATA_WIDTH;
    localparam int          CW          = $clog2(FIFO_DEPTH);
    localparam int          IW          = $clog2(TIMEOUT + 1);
    localparam logic [15:0] NUM_TRANS_C = 16'(NUM_TRANS);
    localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);

    state_t          state_q;
    logic [31:0]     lfsr_q;
    logic [15:0]     issued_q;
    logic [15:0]     received_q;
    logic [15:0]     err_cnt_q;
    logic [IW-1:0]   idle_cnt_q;
    logic [2:0]      phase_q;
    logic            timeout_q;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_clr;
    logic            fifo_pop;
    logic [CW:0]     fifo_count;
    logic [OPW-1:0]  fifo_dout;
    logic            op_hs;
    logic            res_hs;
    logic            timed_out;
    logic            drained;
    logic            mismatch;
    logic [15:0]     issued_d;
    logic [15:0]     received_d;
    logic [63:0]     exp_w;
    logic            unused_bits;

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign timeout   = timeout_q;
    assign err_cnt   = err_cnt_q;
    assign op_val    = (state_q == RUN) && !fifo_full;
    assign res_ready = READY_PAT[phase_q] & busy;
    assign {op_2_im, op_2_re, op_1_im, op_1_re} = op_val ? lfsr_q[OPW-1:0] : '0;

    assign op_hs      = op_val && op_ready;
    assign res_hs     = res_val && res_ready;
    assign fifo_pop   = res_hs && !fifo_empty;
    assign issued_d   = issued_q + 16'(op_hs);
    assign received_d = received_q + 16'(fifo_pop);
    assign timed_out  = busy && (idle_cnt_q == TIMEOUT_C);
    assign drained    = (state_q == DRAIN) && (received_d == NUM_TRANS_C);
    // Leaving for DONE flushes anything a timeout left behind.
    assign fifo_clr   = rst || timed_out || drained;

    assign exp_w = cmul_expected(32'($signed(fifo_dout[DW-1:0])),
                                 32'($signed(fifo_dout[2*DW-1:DW])),
                                 32'($signed(fifo_dout[3*DW-1:2*DW])),
                                 32'($signed(fifo_dout[4*DW-1:3*DW])));
    assign mismatch    = (result_re != exp_w[RW-1:0]) || (result_im != exp_w[32+RW-1:32]);
    assign unused_bits = ^{exp_w[63:32+RW], exp_w[31:RW], fifo_count};

    sync_fifo #(
        .WIDTH (OPW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (fifo_clr),
        .push  (op_hs),
        .pop   (fifo_pop),
        .din   (lfsr_q[OPW-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= LFSR_SEED;
            issued_q   <= '0;
            received_q <= '0;
            err_cnt_q  <= '0;
            idle_cnt_q <= '0;
            phase_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            phase_q <= phase_q + 3'd1;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= RUN;
                        lfsr_q     <= LFSR_SEED;
                        issued_q   <= '0;
                        received_q <= '0;
                        err_cnt_q  <= '0;
                        idle_cnt_q <= '0;
                        timeout_q  <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (op_hs) begin
                        lfsr_q <= lfsr_step(lfsr_q);
                    end
                    issued_q   <= issued_d;
                    received_q <= received_d;
                    // A result with nothing outstanding counts as an error too.
                    if (res_hs && (fifo_empty || mismatch) && (err_cnt_q != 16'hFFFF)) begin
                        err_cnt_q <= err_cnt_q + 16'd1;
                    end
                    idle_cnt_q <= (op_hs || res_hs) ? '0 : idle_cnt_q + IW'(1);
                    if (timed_out) begin
                        state_q   <= DONE;
                        timeout_q <= 1'b1;
                    end else if ((state_q == RUN) && (issued_d == NUM_TRANS_C)) begin
                        state_q <= DRAIN;
                    end else if (drained) begin
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_complex_mult_requester.sv
// ============================================================================
//  Module   : tb_complex_mult_requester
//  Purpose  : Scoreboard bench acting as the multiplier opposite the requester.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_complex_mult_requester;
    import complex_mult_pkg::*;

    localparam int          DW   = 8;
    localparam int          NT   = 16;
    localparam logic [7:0]  PAT  = 8'hA5;
    localparam logic [31:0] SEED = 32'hACE1_5EED;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          op_ready;
    logic          op_val;
    logic [DW-1:0] op_1_re, op_1_im, op_2_re, op_2_im;
    logic          res_val;
    logic [15:0]   result_re, result_im;
    logic          res_ready, busy, done, timeout;
    logic [15:0]   err_cnt;

    always #5 clk = ~clk;

    complex_mult_requester #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4),
        .NUM_TRANS  (NT),
        .LFSR_SEED  (SEED),
        .READY_PAT  (PAT),
        .TIMEOUT    (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_ready  (op_ready),
        .op_val    (op_val),
        .op_1_re   (op_1_re),
        .op_1_im   (op_1_im),
        .op_2_re   (op_2_re),
        .op_2_im   (op_2_im),
        .res_val   (res_val),
        .result_re (result_re),
        .result_im (result_im),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        int          due;
        logic [15:0] re;
        logic [15:0] im;
    } resp_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    resp_t       resp_q[$];
    int          cyc = 0;
    int          lat = 1;
    int          rdy_mode = 0;
    int          flip_idx = -1;
    bit          mute = 0;
    bit          spur = 0;
    bit          post_spur = 0;
    bit          run_active = 0;
    int          op_hs_cnt = 0;
    int          res_acc = 0;
    int          outstanding = 0;
    logic [2:0]  phase_m = 3'd0;
    logic        rst_seen;
    bit          stall_prev = 0;
    logic [31:0] prev_ops, cur_ops, e_ops;
    int          ma, mb, mc, md, re_i, im_i;
    resp_t       r;
    logic [63:0] pk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_model(input logic [31:0] s);
        logic fb;
        fb = s[0];
        return {fb, s[31:1]} ^ (fb ? 32'h0020_0003 : 32'h0);
    endfunction

    // Responder: drives the multiplier side 2ns after each rising edge.
    initial begin
        op_ready = 1'b0; res_val = 1'b0; result_re = '0; result_im = '0;
        forever begin
            @(posedge clk);
            rst_seen = rst;
            #2;
            cyc++;
            phase_m  = rst_seen ? 3'd0 : phase_m + 3'd1;
            op_ready = (rdy_mode == 0) ? !spur : ((cyc % 3) == 0);
            if (spur || post_spur) begin
                res_val = 1'b1; result_re = 16'h1234; result_im = 16'h5678;
            end else if (!mute && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                res_val = 1'b1; result_re = resp_q[0].re; result_im = resp_q[0].im;
            end else begin
                res_val = 1'b0;
            end
        end
    end

    // Monitor: samples on the falling edge the handshakes about to complete.
    initial begin
        forever begin
            @(negedge clk);
            cur_ops = {op_2_im, op_2_re, op_1_im, op_1_re};
            if (busy) check("res_ready_pat", res_ready, PAT[phase_m]);
            else      check("res_ready_idle", res_ready, 0);
            if (stall_prev) begin
                check("op_hold_val", op_val, 1);
                check("op_hold_ops", cur_ops, prev_ops);
            end
            if (run_active && op_hs_cnt < NT) check("op_val_occ", op_val, outstanding < 4);
            stall_prev = op_val && !op_ready && !rst;
            prev_ops   = cur_ops;
            if (op_val && op_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL op_extra: unexpected operand handshake %0h", cur_ops);
                end else begin
                    e_ops = exp_q.pop_front();
                    check("op_operands", cur_ops, e_ops);
                end
                ma = int'($signed(cur_ops[7:0]));   mb = int'($signed(cur_ops[15:8]));
                mc = int'($signed(cur_ops[23:16])); md = int'($signed(cur_ops[31:24]));
                re_i = ma * mc - mb * md;
                im_i = ma * md + mb * mc;
                r.due = cyc + lat;
                r.re  = re_i[15:0];
                r.im  = im_i[15:0] ^ ((op_hs_cnt == flip_idx) ? 16'h0001 : 16'h0000);
                resp_q.push_back(r);
                op_hs_cnt++;
                outstanding++;
            end
            if (res_val && res_ready && !rst) begin
                if (spur) spur = 0;
                else if (resp_q.size() > 0) void'(resp_q.pop_front());
                if (outstanding > 0) begin
                    outstanding--;
                    res_acc++;
                end
            end
        end
    end

    task automatic do_start(input int l, input int rm, input int fi, input bit mu, input bit sp);
        logic [31:0] s;
        @(posedge clk); #1;
        lat = l; rdy_mode = rm; flip_idx = fi; mute = mu; spur = sp; post_spur = 0;
        exp_q.delete(); resp_q.delete();
        s = SEED;
        for (int i = 0; i < NT; i++) begin
            exp_q.push_back(s);
            s = lfsr_model(s);
        end
        op_hs_cnt = 0; res_acc = 0; outstanding = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_active = 1;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
        check("tmo_after_start", timeout, 0);
        check("err_after_start", err_cnt, 0);
    endtask

    task automatic finish_run(input string name, input int bound, input bit tmo,
                              input int err, input int ops, input int res);
        int n;
        n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, done, 1);
        check({name, "_timeout"}, timeout, tmo);
        check({name, "_err_cnt"}, err_cnt, err);
        check({name, "_busy"}, busy, 0);
        check({name, "_op_val"}, op_val, 0);
        check({name, "_issued"}, op_hs_cnt, ops);
        check({name, "_received"}, res_acc, res);
        run_active = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand-computed corner products of the shared reference function.
        pk = cmul_expected(-32'sd128, -32'sd128, -32'sd128, -32'sd128);
        check("corner_re", pk[15:0], 16'h0000);
        check("corner_im", pk[47:32], 16'h8000);
        pk = cmul_expected(32'sd3, 32'sd4, 32'sd1, -32'sd2);
        check("small_re", pk[15:0], 16'h000B);
        check("small_im", pk[47:32], 16'hFFFE);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_op_val", op_val, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_operands", {op_2_im, op_2_re, op_1_im, op_1_re}, 0);

        // Run A: 1-cycle latency, op_ready high, a stray start mid-run.
        do_start(1, 0, -1, 0, 0);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_run("runA", 600, 0, 0, NT, NT);

        // Run B: 3-cycle latency, op_ready high one cycle in three.
        do_start(3, 1, -1, 0, 0);
        finish_run("runB", 800, 0, 0, NT, NT);

        // Run C: spurious early result, flipped im bit on transaction 5.
        do_start(1, 0, 5, 0, 1);
        finish_run("runC", 800, 0, 2, NT, NT);
        @(posedge clk); #1 post_spur = 1;
        repeat (6) @(negedge clk);
        check("post_done_err", err_cnt, 2);
        check("post_done_done", done, 1);
        @(posedge clk); #1 post_spur = 0;

        // Run D: results never return, the run must time out.
        do_start(1, 0, -1, 1, 0);
        finish_run("runD", 1300, 1, 0, 4, 0);

        // Run E: reset in the middle of a run.
        do_start(1, 0, -1, 0, 1);
        repeat (8) @(negedge clk);
        check("err_before_rst", err_cnt, 1);
        @(posedge clk); #1;
        rst = 1'b1; run_active = 0; spur = 0;
        resp_q.delete(); exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_op_val", op_val, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err_cnt, 0);
        check("midrst_res_ready", res_ready, 0);
        check("midrst_operands", {op_2_im, op_2_re, op_1_im, op_1_re}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Run F: clean run from IDLE after the reset.
        do_start(1, 0, -1, 0, 0);
        finish_run("runF", 600, 0, 0, NT, NT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
